wb_counter_bank: RTL and testbench
==================================

WB_COUNTER_BANK -- requirements
Module: wb_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of counter channels (legal 1..16).
REQ-002 SHALL have parameter WIDTH, default 32, counter width in bits (legal 1..32).
REQ-003 SHALL have parameter BASE_ADR, default 32'h3000_0000, Wishbone base address; bits [7:0] ignored.
REQ-004 SHALL have port wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone classic cycle, strobe, write enable.
REQ-007 SHALL have ports wbs_sel_i  input  4, wbs_adr_i  input  32, wbs_dat_i  input  32  byte selects, address, write data.
REQ-008 SHALL have ports wbs_ack_o  output  1, wbs_dat_o  output  32  acknowledge, read data.
REQ-009 SHALL have port match_o  output  NUM_CH  per-channel one-cycle match pulse.
REQ-010 SHALL have port irq_o  output  1  OR over channels of (FLAG & IRQ_EN).

Function
REQ-011 Decode SHALL hit when cyc&stb and adr[31:8]==BASE_ADR[31:8]; channel=adr[7:4], register=adr[3:2]; no hit -> no ack, no side effect.
REQ-012 Per-channel registers SHALL be: 0x0 CTRL, 0x4 COUNT (R/W), 0x8 MATCH (R/W), 0xC RELOAD (R/W).
REQ-013 CTRL bits SHALL be: [0] EN, [1] DOWN, [2] AUTO_RELOAD, [3] IRQ_EN, [8] FLAG (read; write-1-clears); other bits read 0.
REQ-014 wbs_ack_o SHALL assert exactly one cycle after a hit, for one cycle, and not in the cycle following an ack (a held strobe gets ack every other cycle).
REQ-015 Writes SHALL take effect on the acking edge, honouring wbs_sel_i per byte; bits above WIDTH dropped.
REQ-016 wbs_dat_o SHALL be valid with ack, zero-extended from WIDTH; 0 when ack low.
REQ-017 Hit with channel >= NUM_CH SHALL ack, read 0, ignore writes.
REQ-018 When EN=1 each cycle: if COUNT==MATCH -> FLAG<=1, match_o pulses next cycle, COUNT<=RELOAD if AUTO_RELOAD else normal step; otherwise step.
REQ-019 Step SHALL be COUNT+1 (DOWN=0) or COUNT-1 (DOWN=1), modulo 2^WIDTH (wrap 2^WIDTH-1 <-> 0, no flag on wrap).
REQ-020 EN=0 SHALL hold COUNT; no match evaluation.
REQ-021 A Wishbone write to COUNT SHALL override the counter step and reload in the same cycle.
REQ-022 Simultaneous FLAG set and W1C SHALL leave FLAG=1.
REQ-023 irq_o SHALL be registered, one cycle after FLAG/IRQ_EN change.

Reset
REQ-024 wb_rst_i SHALL immediately clear all CTRL, COUNT, MATCH, RELOAD, FLAG, wbs_ack_o, wbs_dat_o, match_o, irq_o to 0, including mid-transaction; the interrupted cycle is not acked.
REQ-025 After reset release the first hit SHALL behave per REQ-014.

Structure
REQ-026 A shared package SHALL hold register offsets, CTRL bit positions and channel stride (16 bytes).
REQ-027 Per-channel logic SHALL be one sub-module wb_counter_ch, instantiated NUM_CH times via generate; top holds decode, ack, read mux, irq OR.

Verification
REQ-028 Write COUNT=5, MATCH=8, CTRL=0x1 -> COUNT reads 8 after 3 enabled cycles, match_o pulse, FLAG=1, irq_o stays 0.
REQ-029 DOWN=1, COUNT=0, MATCH=0xFFFF_FFF0 (WIDTH=32) -> next COUNT 0xFFFF_FFFF, no FLAG.
REQ-030 AUTO_RELOAD, RELOAD=2, MATCH=4, IRQ_EN -> COUNT sequence 2,3,4,2,3; irq_o high; CTRL write 0x10F clears FLAG, irq_o low next cycle.
REQ-031 Byte write sel=4'b0010 data 0xAABBCCDD to MATCH=0 -> MATCH reads 0x0000CC00; WIDTH=8 build reads 0x00.
REQ-032 Access channel 5 with NUM_CH=4 -> ack, read 0; address outside BASE_ADR[31:8] -> no ack for 8 cycles.
REQ-033 Assert wb_rst_i while strobe pending and EN=1 -> no ack, all registers 0, counting stopped.

Source files
------------

// File: rtl/wb_counter_bank_pkg.sv
`default_nettype none
// ============================================================================
// wb_counter_bank_pkg : register map, CTRL bit positions and byte-merge helper
// Revision: 1.0
// ============================================================================
package wb_counter_bank_pkg;

   localparam logic [1:0] c_reg_ctrl   = 2'd0;
   localparam logic [1:0] c_reg_count  = 2'd1;
   localparam logic [1:0] c_reg_match  = 2'd2;
   localparam logic [1:0] c_reg_reload = 2'd3;

   localparam int c_ctrl_en      = 0;
   localparam int c_ctrl_down    = 1;
   localparam int c_ctrl_auto    = 2;
   localparam int c_ctrl_irq_en  = 3;
   localparam int c_ctrl_flag    = 8;

   localparam int c_ch_stride    = 16;
   localparam int c_ch_shift     = $clog2(c_ch_stride);

   function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_counter_bank_ch.sv
`default_nettype none
// ============================================================================
// wb_counter_ch : one counter channel (CTRL/COUNT/MATCH/RELOAD + match logic)
// Revision: 1.0
// ============================================================================
module wb_counter_ch
   import wb_counter_bank_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_i,
   input  logic [1:0]  reg_i,
   input  logic [31:0] dat_i,
   input  logic [3:0]  sel_i,
   output logic [31:0] rdat_o,
   output logic        match_o,
   output logic        flag_o,
   output logic        irq_en_o
);

   localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

   logic [3:0]       ctrl_q,   ctrl_d;
   logic             flag_q,   flag_d;
   logic             pulse_q,  pulse_d;
   logic [WIDTH-1:0] count_q,  count_d;
   logic [WIDTH-1:0] match_q,  match_d;
   logic [WIDTH-1:0] reload_q, reload_d;

   logic [31:0]      w_count_wr, w_match_wr, w_reload_wr, w_ctrl_rd;
   logic [WIDTH-1:0] w_step;
   logic             w_hit, w_w1c;

   assign w_count_wr  = byte_merge(32'(count_q),  dat_i, sel_i);
   assign w_match_wr  = byte_merge(32'(match_q),  dat_i, sel_i);
   assign w_reload_wr = byte_merge(32'(reload_q), dat_i, sel_i);
   assign w_step      = ctrl_q[c_ctrl_down] ? count_q - c_one : count_q + c_one;
   assign w_hit       = ctrl_q[c_ctrl_en] && (count_q == match_q);
   assign w_w1c       = wr_i && (reg_i == c_reg_ctrl) && sel_i[1] && dat_i[c_ctrl_flag];

   always_comb begin
      ctrl_d   = ctrl_q;
      count_d  = count_q;
      match_d  = match_q;
      reload_d = reload_q;
      pulse_d  = w_hit;
      // a match in the same cycle as a W1C wins, so the event is never lost
      flag_d   = (flag_q && !w_w1c) || w_hit;
      if (ctrl_q[c_ctrl_en]) begin
         count_d = (w_hit && ctrl_q[c_ctrl_auto]) ? reload_q : w_step;
      end
      if (wr_i) begin
         case (reg_i)
            c_reg_ctrl:   if (sel_i[0]) ctrl_d = dat_i[3:0];
            c_reg_count:  count_d  = w_count_wr[WIDTH-1:0];
            c_reg_match:  match_d  = w_match_wr[WIDTH-1:0];
            default:      reload_d = w_reload_wr[WIDTH-1:0];
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ctrl_q   <= '0;
         flag_q   <= 1'b0;
         pulse_q  <= 1'b0;
         count_q  <= '0;
         match_q  <= '0;
         reload_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         flag_q   <= flag_d;
         pulse_q  <= pulse_d;
         count_q  <= count_d;
         match_q  <= match_d;
         reload_q <= reload_d;
      end
   end

   always_comb begin
      w_ctrl_rd              = '0;
      w_ctrl_rd[3:0]         = ctrl_q;
      w_ctrl_rd[c_ctrl_flag] = flag_q;
      case (reg_i)
         c_reg_ctrl:  rdat_o = w_ctrl_rd;
         c_reg_count: rdat_o = 32'(count_q);
         c_reg_match: rdat_o = 32'(match_q);
         default:     rdat_o = 32'(reload_q);
      endcase
   end

   assign match_o  = pulse_q;
   assign flag_o   = flag_q;
   assign irq_en_o = ctrl_q[c_ctrl_irq_en];

endmodule
`default_nettype wire

// File: rtl/wb_counter_bank.sv
`default_nettype none
// ============================================================================
// wb_counter_bank : Wishbone-classic slave with NUM_CH match/reload counters
// Revision: 1.0
// ============================================================================
module wb_counter_bank
   import wb_counter_bank_pkg::*;
#(
   parameter int          NUM_CH   = 4,
   parameter int          WIDTH    = 32,
   parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              wbs_cyc_i,
   input  logic              wbs_stb_i,
   input  logic              wbs_we_i,
   input  logic [3:0]        wbs_sel_i,
   input  logic [31:0]       wbs_adr_i,
   input  logic [31:0]       wbs_dat_i,
   output logic              wbs_ack_o,
   output logic [31:0]       wbs_dat_o,
   output logic [NUM_CH-1:0] match_o,
   output logic              irq_o
);

   logic        ack_q, ack_d;
   logic [31:0] dat_q, dat_d;
   logic        irq_q, irq_d;

   logic              w_hit, w_wr;
   logic [3:0]        w_ch;
   logic [1:0]        w_reg;
   logic [31:0]       w_rdat;
   logic [31:0]       w_ch_rdat [NUM_CH];
   logic [NUM_CH-1:0] w_flag, w_irq_en;
   logic              w_unused;

   assign w_hit    = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:8] == BASE_ADR[31:8]);
   assign w_ch     = wbs_adr_i[c_ch_shift +: 4];
   assign w_reg    = wbs_adr_i[3:2];
   assign w_unused = ^wbs_adr_i[1:0];

   // the cycle after an ack never acks, so a held strobe is not double-counted
   assign ack_d = w_hit && !ack_q;
   assign w_wr  = ack_d && wbs_we_i;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         wb_counter_ch #(.WIDTH(WIDTH)) u_ch (
            .clk_i    (wb_clk_i),
            .rst_i    (wb_rst_i),
            .wr_i     (w_wr && (w_ch == 4'(gi))),
            .reg_i    (w_reg),
            .dat_i    (wbs_dat_i),
            .sel_i    (wbs_sel_i),
            .rdat_o   (w_ch_rdat[gi]),
            .match_o  (match_o[gi]),
            .flag_o   (w_flag[gi]),
            .irq_en_o (w_irq_en[gi])
         );
      end
   endgenerate

   // unpopulated channels match no index and therefore read as zero
   always_comb begin
      w_rdat = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_ch == 4'(i)) w_rdat = w_ch_rdat[i];
      end
   end

   assign dat_d = ack_d ? w_rdat : '0;
   assign irq_d = |(w_flag & w_irq_en);

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q <= 1'b0;
         dat_q <= '0;
         irq_q <= 1'b0;
      end else begin
         ack_q <= ack_d;
         dat_q <= dat_d;
         irq_q <= irq_d;
      end
   end

   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = dat_q;
   assign irq_o     = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_counter_bank.sv
`default_nettype none
// ============================================================================
// tb_wb_counter_bank : directed self-checking bench for wb_counter_bank
// Revision: 1.0
// ============================================================================
module tb_wb_counter_bank;

   logic        clk, rst, cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, wdat;
   logic        ack, irq, ack8, irq8;
   logic [31:0] rdat, rdat8;
   logic [3:0]  match;
   logic [1:0]  match8;

   int n_cmp  = 0;
   int n_fail = 0;

   wb_counter_bank #(.NUM_CH(4), .WIDTH(32), .BASE_ADR(32'h3000_0000)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack),
      .wbs_dat_o(rdat), .match_o(match), .irq_o(irq));

   wb_counter_bank #(.NUM_CH(2), .WIDTH(8), .BASE_ADR(32'h3000_0000)) dut8 (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
      .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack8),
      .wbs_dat_o(rdat8), .match_o(match8), .irq_o(irq8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] a(input int ch, input int r);
      return {24'h3000_00, 4'(ch), 2'(r), 2'b00};
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic xfer(input logic w, input logic [31:0] ad, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic [31:0] rd8,
                       output int lat);
      cyc = 1'b1; stb = 1'b1; we = w; adr = ad; wdat = d; sel = s;
      lat = 0; rd = '0; rd8 = '0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (ack) begin
            lat = k; rd = rdat; rd8 = rdat8;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      if (lat == 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wr(input int ch, input int r, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] x, x8;
      int l;
      xfer(1'b1, a(ch, r), d, s, x, x8, l);
   endtask

   task automatic rd(input int ch, input int r, output logic [31:0] v, output logic [31:0] v8);
      int l;
      xfer(1'b0, a(ch, r), 32'd0, 4'hF, v, v8, l);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      logic [31:0] v, v8;
      int lat, acks;
      rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = '0; wdat = '0;
      repeat (2) @(negedge clk);
      chk("rst_ack",   32'(ack),   32'd0);
      chk("rst_dat",   rdat,       32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_irq",   32'(irq),   32'd0);
      rst = 1'b0;

      // first hit after reset acks after exactly one edge
      xfer(1'b0, a(0, 0), 32'd0, 4'hF, v, v8, lat);
      chk("first_lat",  32'(lat), 32'd1);
      chk("first_ctrl", v,        32'd0);

      // held strobe: ack every other cycle
      idle(1);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a(0, 1); acks = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         @(negedge clk);
         acks += int'(ack);
      end
      cyc = 1'b0; stb = 1'b0;
      chk("held_acks", 32'(acks), 32'd3);
      idle(1);
      chk("dat_idle", rdat, 32'd0);

      // byte lanes and width truncation
      wr(0, 2, 32'hAABB_CCDD, 4'b0010);
      rd(0, 2, v, v8);
      chk("bytesel_match",  v,  32'h0000_CC00);
      chk("bytesel_match8", v8, 32'h0000_0000);
      wr(0, 1, 32'h0000_01FF, 4'hF);
      rd(0, 1, v, v8);
      chk("count_full",  v,  32'h0000_01FF);
      chk("count_trunc", v8, 32'h0000_00FF);
      do_reset();

      // up-count to match
      wr(0, 1, 32'd5, 4'hF);
      wr(0, 2, 32'd8, 4'hF);
      wr(0, 0, 32'h1, 4'hF);
      idle(3);
      rd(0, 1, v, v8);
      chk("up_count8",  v,          32'd8);
      chk("up_match_o", 32'(match), 32'h1);
      rd(0, 0, v, v8);
      chk("up_ctrl_flag", v,          32'h101);
      chk("up_irq",       32'(irq),   32'd0);
      chk("up_match_end", 32'(match), 32'd0);
      do_reset();

      // down-count wrap without flag
      wr(0, 2, 32'hFFFF_FFF0, 4'hF);
      wr(0, 0, 32'h3, 4'hF);
      idle(1);
      rd(0, 1, v, v8);
      chk("down_wrap", v, 32'hFFFF_FFFF);
      rd(0, 0, v, v8);
      chk("down_noflag", v, 32'h3);
      do_reset();

      // auto reload 2,3,4,2,3 with interrupt
      wr(0, 1, 32'd2, 4'hF);
      wr(0, 3, 32'd2, 4'hF);
      wr(0, 2, 32'd4, 4'hF);
      wr(0, 0, 32'hD, 4'hF);
      rd(0, 1, v, v8);
      chk("ar_seq_a", v, 32'd3);
      chk("ar_irq_lo", 32'(irq), 32'd0);
      rd(0, 1, v, v8);
      chk("ar_seq_b", v, 32'd2);
      chk("ar_irq_hi", 32'(irq), 32'd1);
      rd(0, 1, v, v8);
      chk("ar_seq_c", v, 32'd4);
      chk("ar_match_o", 32'(match), 32'h1);
      rd(0, 1, v, v8);
      chk("ar_seq_d", v, 32'd3);
      wr(0, 0, 32'h10F, 4'hF);
      chk("w1c_irq_still", 32'(irq), 32'd1);
      idle(1);
      chk("w1c_irq_low", 32'(irq), 32'd0);
      rd(0, 0, v, v8);
      chk("w1c_ctrl", v, 32'h00F);
      do_reset();

      // W1C coinciding with a match keeps FLAG
      wr(0, 2, 32'd2, 4'hF);
      wr(0, 0, 32'h9, 4'hF);
      idle(2);
      wr(0, 0, 32'h109, 4'hF);
      rd(0, 0, v, v8);
      chk("w1c_race_flag", v, 32'h109);
      chk("w1c_race_irq", 32'(irq), 32'd1);
      do_reset();

      // unpopulated channel and foreign address
      xfer(1'b1, a(5, 1), 32'h1234, 4'hF, v, v8, lat);
      chk("ch5_wr_lat", 32'(lat), 32'd1);
      rd(5, 1, v, v8);
      chk("ch5_rd", v, 32'd0);
      rd(0, 1, v, v8);
      chk("ch0_untouched", v, 32'd0);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0104; acks = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         acks += int'(ack);
      end
      cyc = 1'b0; stb = 1'b0;
      chk("nohit_acks", 32'(acks), 32'd0);

      // asynchronous reset during a transaction with counting enabled
      wr(0, 1, 32'd10, 4'hF);
      wr(0, 0, 32'h1, 4'hF);
      idle(2);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a(0, 1);
      @(posedge clk);
      #1;
      chk("pre_rst_ack", 32'(ack), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_ack", 32'(ack), 32'd0);
      chk("async_dat", rdat,     32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("rst_hold_ack", 32'(ack), 32'd0);
      cyc = 1'b0; stb = 1'b0;
      rst = 1'b0;
      idle(3);
      rd(0, 1, v, v8);
      chk("rst_count", v, 32'd0);
      rd(0, 0, v, v8);
      chk("rst_ctrl", v, 32'd0);
      rd(0, 1, v, v8);
      chk("rst_count_stopped", v, 32'd0);
      chk("rst_irq_end", 32'(irq), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
